// File: rtl/doc_stream_scheduler.sv
// doc_stream_scheduler
//
// Reads the whole character document out in row-major order and streams it
// byte by byte toward the UART transmitter. It requests the document's shared
// read port for every address. It substitutes BLANK for empty (8'h00) cells.
// When EOL_EN is set, it appends NEWLINE after the last column of each row.
// A one-cycle done pulse marks the end of a complete dump. That pulse drives
// the editor's clear_data hook.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active low
//   start     one-cycle dump request, honoured only while idle
//   doc_req   request for the document read port
//   doc_gnt   port granted this cycle; doc_data is valid in the same cycle
//   doc_addr  document address {row, col}, driven while requesting
//   doc_data  document read data (combinational read)
//   tx_data   byte offered to the transmitter
//   tx_valid  tx_data is valid
//   tx_ready  transmitter accepts the byte at this edge when tx_valid is high
//   busy      a dump is in progress (registered)
//   done      one-cycle completion pulse
//
// Handshakes
//   Both interfaces use strict valid/ready semantics. A transfer happens
//   only at a rising edge where the request/valid side and the grant/ready
//   side are both high. Once doc_req or tx_valid is raised, it stays high
//   and its payload (doc_addr or tx_data) stays frozen until that transfer
//   edge. The two request sides come from mutually exclusive states, so
//   doc_req and tx_valid are never high together.

module doc_stream_scheduler #(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 5,
  parameter bit          EOL_EN   = 1'b1,
  parameter logic [7:0]  NEWLINE  = 8'h0A,
  parameter logic [7:0]  BLANK    = 8'h20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         doc_req,
  input  logic                         doc_gnt,
  output logic [ROW_BITS+COL_BITS-1:0] doc_addr,
  input  logic [7:0]                   doc_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_SEND = 3'd2,
    S_EOL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
  localparam logic [COL_BITS-1:0] COL_LAST = '1;
  localparam logic [ROW_BITS-1:0] ROW_INC  = 1;
  localparam logic [COL_BITS-1:0] COL_INC  = 1;

  state_t              state;
  state_t              state_nx;
  logic [ROW_BITS-1:0] row;
  logic [ROW_BITS-1:0] row_nx;
  logic [COL_BITS-1:0] col;
  logic [COL_BITS-1:0] col_nx;
  logic [7:0]          tx_data_nx;
  logic                row_last;
  logic                col_last;

  assign row_last = (row == ROW_LAST);
  assign col_last = (col == COL_LAST);

  // State, position counters and the transmit byte register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      row     <= row_nx;
      col     <= col_nx;
      tx_data <= tx_data_nx;
      // Registering the next-state decode makes busy equal to
      // (state != S_IDLE) while still coming straight from a flop.
      busy    <= (state_nx != S_IDLE);
    end
  end

  // Next-state logic. The terminal checks are evaluated before any counter
  // increment, so the position never wraps past the last address.
  always_comb begin
    state_nx   = state;
    row_nx     = row;
    col_nx     = col;
    tx_data_nx = tx_data;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_REQ;
          row_nx   = '0;
          col_nx   = '0;
        end
      end
      S_REQ: begin
        if (doc_gnt) begin
          tx_data_nx = (doc_data == 8'h00) ? BLANK : doc_data;
          state_nx   = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (col_last && EOL_EN) begin
            // The newline is loaded here so tx_data is already stable on
            // the first cycle tx_valid is high in S_EOL.
            tx_data_nx = NEWLINE;
            state_nx   = S_EOL;
          end else if (row_last && col_last) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_REQ;
            if (col_last) begin
              col_nx = '0;
              row_nx = row + ROW_INC;
            end else begin
              col_nx = col + COL_INC;
            end
          end
        end
      end
      S_EOL: begin
        if (tx_ready) begin
          if (row_last) begin
            state_nx = S_DONE;
          end else begin
            row_nx   = row + ROW_INC;
            col_nx   = '0;
            state_nx = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state. The address is presented
  // only while requesting, which keeps the shared port quiet otherwise.
  assign doc_req  = (state == S_REQ);
  assign doc_addr = (state == S_REQ) ? {row, col} : '0;
  assign tx_valid = (state == S_SEND) || (state == S_EOL);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_doc_stream_scheduler.sv
// Testbench for doc_stream_scheduler.
// u0 uses the default parameters and a document that holds addr[7:0] | 8'h40.
// u1 runs with EOL_EN=0 over an all-zero document.

module tb_doc_stream_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- u0 signals ----------------
  logic       start = 1'b0;
  logic       doc_req;
  logic       doc_gnt = 1'b1;
  logic [8:0] doc_addr;
  logic [7:0] doc_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       done;

  // ---------------- u1 signals ----------------
  logic       u1_start = 1'b0;
  logic       u1_doc_req;
  logic       u1_doc_gnt = 1'b1;
  logic [8:0] u1_doc_addr;
  logic [7:0] u1_doc_data;
  logic [7:0] u1_tx_data;
  logic       u1_tx_valid;
  logic       u1_tx_ready = 1'b1;
  logic       u1_busy;
  logic       u1_done;

  // Document models (combinational read).
  assign doc_data    = doc_addr[7:0] | 8'h40;
  assign u1_doc_data = 8'h00;

  doc_stream_scheduler u0 (
    .clk(clk), .rst(rst), .start(start),
    .doc_req(doc_req), .doc_gnt(doc_gnt), .doc_addr(doc_addr), .doc_data(doc_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  doc_stream_scheduler #(.EOL_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(u1_start),
    .doc_req(u1_doc_req), .doc_gnt(u1_doc_gnt), .doc_addr(u1_doc_addr), .doc_data(u1_doc_data),
    .tx_data(u1_tx_data), .tx_valid(u1_tx_valid), .tx_ready(u1_tx_ready),
    .busy(u1_busy), .done(u1_done)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] nostall_q[$];
  logic [7:0] u1_exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         done_total = 0;
  int         u1_done_total = 0;
  int         u1_bytes = 0;
  logic [8:0] u1_gidx = '0;
  bit         bp_mode = 1'b0;
  bit         stall_mode = 1'b0;
  int         stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected byte stream of one full u0 dump: row-major characters plus a
  // newline after every row.
  task automatic push_dump();
    logic [8:0] a;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 32; c++) begin
        a = {r[3:0], c[4:0]};
        exp_q.push_back(a[7:0] | 8'h40);
      end
      exp_q.push_back(8'h0A);
    end
  endtask

  // ---------------- drivers ----------------
  // The grant and ready responders update just after each rising edge. They
  // withhold the grant for 5 cycles on address 9'h021 when stall_mode is set.
  always @(posedge clk) begin
    #1;
    tx_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    if (stall_mode && doc_req && (doc_addr == 9'h021) && (stall_cnt < 5)) begin
      doc_gnt = 1'b0;
      stall_cnt++;
    end else begin
      doc_gnt = 1'b1;
    end
  end

  // Pulse start so that exactly one rising edge samples it. Returns 1 time
  // unit after that sampling edge.
  task automatic pulse_start(input bit which);
    @(posedge clk);
    #1;
    if (which) u1_start = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    u1_start = 1'b0;
    start    = 1'b0;
  endtask

  // Waits for u0's done pulse and returns the 1-based cycle after the start
  // sampling edge in which done was seen (0 if the budget ran out). When
  // inject_at >= 0, a second start pulse is issued once that many bytes have
  // been accepted.
  task automatic wait_dump(input string tag, input int budget, input int inject_at,
                           output int done_cyc);
    bit injected;
    injected = 1'b0;
    done_cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_first_req"}, {busy, doc_req, doc_addr}, {1'b1, 1'b1, 9'h000});
      end
      if (inject_at >= 0 && !injected && got_q.size() >= inject_at) begin
        start    = 1'b1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = i;
        break;
      end
    end
    start = 1'b0;
    if (done_cyc == 0) $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  bit         hold_tx = 1'b0;
  logic [7:0] held_data = '0;
  bit         hold_req = 1'b0;
  logic [8:0] held_addr = '0;
  bit         prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (doc_req && tx_valid) check("req_valid_exclusive", 1, 0);
      if (hold_tx) check("tx_hold", {tx_valid, tx_data}, {1'b1, held_data});
      if (hold_req) check("req_hold", {doc_req, doc_addr}, {1'b1, held_addr});
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", tx_data, 8'h00);
          if (tx_data == 8'h00) begin
            n_err++;
            $display("FAIL unexpected_byte: got 0x00 with nothing expected");
          end
        end else begin
          check("byte", tx_data, exp_q.pop_front());
        end
      end
      if (done) begin
        done_total++;
        check("busy_at_done", busy, 1);
      end
      if (prev_done) check("busy_after_done", busy, 0);
    end
    hold_tx   = rst && tx_valid && !tx_ready;
    held_data = tx_data;
    hold_req  = rst && doc_req && !doc_gnt;
    held_addr = doc_addr;
    prev_done = rst && done;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (u1_doc_req && u1_tx_valid) check("u1_req_valid_exclusive", 1, 0);
      if (u1_doc_req && u1_doc_gnt) begin
        check("u1_addr", u1_doc_addr, u1_gidx);
        u1_gidx++;
      end
      if (u1_tx_valid && u1_tx_ready) begin
        u1_bytes++;
        if (u1_exp_q.size() == 0) begin
          n_err++;
          $display("FAIL u1_unexpected_byte: got 0x%0h with nothing expected", u1_tx_data);
        end else begin
          check("u1_byte", u1_tx_data, u1_exp_q.pop_front());
        end
      end
      if (u1_done) begin
        u1_done_total++;
        check("u1_busy_at_done", u1_busy, 1);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int dc;
    int diffs;

    // Reset values: reset held with start/gnt/ready asserted.
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", {doc_req, tx_valid, busy, done, tx_data, doc_addr}, 21'h0);
    end
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_idle", {doc_req, tx_valid, busy, done}, 4'h0);
    end

    // Full dump without stalls.
    got_q.delete();
    push_dump();
    d0 = done_total;
    pulse_start(1'b0);
    wait_dump("nostall", 1500, -1, dc);
    check("nostall_done_cycle", dc, 1041);
    check("nostall_done_count", done_total - d0, 1);
    check("nostall_bytes", got_q.size(), 528);
    check("nostall_q_empty", exp_q.size(), 0);
    check("nostall_byte32", got_q[32], 8'h0A);
    check("nostall_byte33", got_q[33], 8'h60);
    nostall_q = got_q;

    // Backpressure plus a 5-cycle grant stall on address 9'h021.
    got_q.delete();
    push_dump();
    d0         = done_total;
    stall_cnt  = 0;
    bp_mode    = 1'b1;
    stall_mode = 1'b1;
    pulse_start(1'b0);
    wait_dump("bp", 6000, -1, dc);
    bp_mode    = 1'b0;
    stall_mode = 1'b0;
    check("bp_done_seen", (dc != 0), 1);
    check("bp_done_count", done_total - d0, 1);
    check("bp_stall_cycles", stall_cnt, 5);
    check("bp_bytes", got_q.size(), nostall_q.size());
    diffs = 0;
    for (int i = 0; i < got_q.size() && i < nostall_q.size(); i++) begin
      if (got_q[i] !== nostall_q[i]) diffs++;
    end
    check("bp_seq_vs_nostall", diffs, 0);
    check("bp_q_empty", exp_q.size(), 0);

    // Blank substitution with EOL_EN=0 on u1.
    for (int i = 0; i < 512; i++) u1_exp_q.push_back(8'h20);
    u1_bytes = 0;
    dc = 0;
    pulse_start(1'b1);
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      if (u1_done) begin
        dc = i;
        break;
      end
    end
    repeat (3) @(negedge clk);
    check("u1_done_cycle", dc, 1025);
    check("u1_done_count", u1_done_total, 1);
    check("u1_bytes", u1_bytes, 512);
    check("u1_q_empty", u1_exp_q.size(), 0);
    check("u1_idle_after", u1_busy, 0);

    // Start while busy: a second start at byte 100 must be ignored.
    got_q.delete();
    push_dump();
    d0 = done_total;
    pulse_start(1'b0);
    wait_dump("busy_start", 1500, 100, dc);
    check("busy_start_done_count", done_total - d0, 1);
    check("busy_start_bytes", got_q.size(), 528);
    check("busy_start_q_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("busy_start_not_queued", {busy, doc_req}, 2'b00);

    // Reset in the middle of a dump.
    got_q.delete();
    push_dump();
    pulse_start(1'b0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (got_q.size() >= 200) break;
    end
    check("abort_reached_200", (got_q.size() >= 200), 1);
    d0 = done_total;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_reset_outs", {doc_req, tx_valid, busy, done, tx_data, doc_addr}, 21'h0);
    rst = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("abort_no_done", done_total - d0, 0);
    check("abort_idle", {busy, doc_req, tx_valid}, 3'b000);

    got_q.delete();
    push_dump();
    d0 = done_total;
    pulse_start(1'b0);
    wait_dump("restart", 1500, -1, dc);
    check("restart_done_cycle", dc, 1041);
    check("restart_done_count", done_total - d0, 1);
    check("restart_bytes", got_q.size(), 528);
    check("restart_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
